regfile_wb_arbiter: RTL and testbench

- Shares the single write port of the 32x32 register file between two writeback sources: ALU result and memory load.
- Each source has a valid/ready handshake and a one-entry holding register.
- A round-robin arbiter with age override drives the register file's registered write port (wr, reg_id_w, data_in).
- A pending-write scoreboard query lets decode stall on read-after-write to a not-yet-written register.

---
 rtl/regfile_wb_arbiter.sv | 154 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares the register file write port between ALU and load results,
// using one holding register per source, round-robin with an age override, and a pending-write scoreboard.
module regfile_wb_arbiter #(
    parameter int N     = 32,
    parameter int R     = 32,
    parameter int ASIZE = $clog2(R)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [ASIZE-1:0] alu_id,
    input  logic [N-1:0]     alu_data,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [ASIZE-1:0] mem_id,
    input  logic [N-1:0]     mem_data,
    output logic             wr,
    output logic [ASIZE-1:0] reg_id_w,
    output logic [N-1:0]     data_in,
    input  logic [ASIZE-1:0] q_id1,
    input  logic [ASIZE-1:0] q_id2,
    output logic             q_hit1,
    output logic             q_hit2
);
    logic             held_alu_q, held_alu_d;
    logic [ASIZE-1:0] alu_id_q, alu_id_d;
    logic [N-1:0]     alu_data_q, alu_data_d;
    logic             held_mem_q, held_mem_d;
    logic [ASIZE-1:0] mem_id_q, mem_id_d;
    logic [N-1:0]     mem_data_q, mem_data_d;
    // Set when the held ALU entry was captured strictly before the held load entry.
    logic             alu_older_q, alu_older_d;
    logic             rr_alu_q, rr_alu_d;
    logic             wr_q, wr_d;
    logic [ASIZE-1:0] reg_id_w_q, reg_id_w_d;
    logic [N-1:0]     data_in_q, data_in_d;
    logic             grant_alu_s, grant_mem_s, cap_alu_s, cap_mem_s;

    // Grant selection over the held entries.
    always_comb begin
        grant_alu_s = 1'b0;
        grant_mem_s = 1'b0;
        if (held_alu_q && held_mem_q) begin
            if (alu_id_q == mem_id_q) begin
                grant_alu_s = alu_older_q;
            end else begin
                grant_alu_s = rr_alu_q;
            end
            grant_mem_s = ~grant_alu_s;
        end else begin
            grant_alu_s = held_alu_q;
            grant_mem_s = held_mem_q;
        end
    end

    assign alu_ready = ~held_alu_q | grant_alu_s;
    assign mem_ready = ~held_mem_q | grant_mem_s;
    // Writes to register 0 are accepted but dropped here, so they never occupy a slot.
    assign cap_alu_s = alu_valid & alu_ready & (alu_id != {ASIZE{1'b0}});
    assign cap_mem_s = mem_valid & mem_ready & (mem_id != {ASIZE{1'b0}});

    // Next-state for holding registers, age flag, pointer and write port.
    always_comb begin
        held_alu_d  = held_alu_q;
        alu_id_d    = alu_id_q;
        alu_data_d  = alu_data_q;
        held_mem_d  = held_mem_q;
        mem_id_d    = mem_id_q;
        mem_data_d  = mem_data_q;
        alu_older_d = alu_older_q;
        rr_alu_d    = rr_alu_q;
        wr_d        = 1'b0;
        reg_id_w_d  = reg_id_w_q;
        data_in_d   = data_in_q;
        if (cap_alu_s) begin
            held_alu_d = 1'b1;
            alu_id_d   = alu_id;
            alu_data_d = alu_data;
        end else if (grant_alu_s) begin
            held_alu_d = 1'b0;
        end else begin
            held_alu_d = held_alu_q;
        end
        if (cap_mem_s) begin
            held_mem_d = 1'b1;
            mem_id_d   = mem_id;
            mem_data_d = mem_data;
        end else if (grant_mem_s) begin
            held_mem_d = 1'b0;
        end else begin
            held_mem_d = held_mem_q;
        end
        // A same-edge capture leaves the load as the older one.
        if (cap_alu_s) begin
            alu_older_d = 1'b0;
        end else if (cap_mem_s) begin
            alu_older_d = 1'b1;
        end else begin
            alu_older_d = alu_older_q;
        end
        if (grant_alu_s || grant_mem_s) begin
            wr_d       = 1'b1;
            rr_alu_d   = grant_mem_s;
            reg_id_w_d = grant_alu_s ? alu_id_q : mem_id_q;
            data_in_d  = grant_alu_s ? alu_data_q : mem_data_q;
        end else begin
            wr_d       = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_alu_q  <= 1'b0;
            alu_id_q    <= {ASIZE{1'b0}};
            alu_data_q  <= {N{1'b0}};
            held_mem_q  <= 1'b0;
            mem_id_q    <= {ASIZE{1'b0}};
            mem_data_q  <= {N{1'b0}};
            alu_older_q <= 1'b0;
            rr_alu_q    <= 1'b1;
            wr_q        <= 1'b0;
            reg_id_w_q  <= {ASIZE{1'b0}};
            data_in_q   <= {N{1'b0}};
        end else begin
            held_alu_q  <= held_alu_d;
            alu_id_q    <= alu_id_d;
            alu_data_q  <= alu_data_d;
            held_mem_q  <= held_mem_d;
            mem_id_q    <= mem_id_d;
            mem_data_q  <= mem_data_d;
            alu_older_q <= alu_older_d;
            rr_alu_q    <= rr_alu_d;
            wr_q        <= wr_d;
            reg_id_w_q  <= reg_id_w_d;
            data_in_q   <= data_in_d;
        end
    end

    assign wr       = wr_q;
    assign reg_id_w = reg_id_w_q;
    assign data_in  = data_in_q;

    // The in-flight write still counts as pending: the register file commits it next edge.
    assign q_hit1 = (q_id1 != {ASIZE{1'b0}}) &
                    ((held_alu_q & (alu_id_q == q_id1)) |
                     (held_mem_q & (mem_id_q == q_id1)) |
                     (wr_q & (reg_id_w_q == q_id1)));
    assign q_hit2 = (q_id2 != {ASIZE{1'b0}}) &
                    ((held_alu_q & (alu_id_q == q_id2)) |
                     (held_mem_q & (mem_id_q == q_id2)) |
                     (wr_q & (reg_id_w_q == q_id2)));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic checked against a
// model that tracks accepted writes in age order per register.
module tb_regfile_wb_arbiter;
    localparam int N  = 32;
    localparam int R  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, alu_ready, mem_valid, mem_ready;
    logic [AW-1:0] alu_id, mem_id, reg_id_w, q_id1, q_id2;
    logic [N-1:0]  alu_data, mem_data, data_in;
    logic          wr, q_hit1, q_hit2;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.N(N), .R(R), .ASIZE(AW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_id(alu_id), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_id(mem_id), .mem_data(mem_data),
        .wr(wr), .reg_id_w(reg_id_w), .data_in(data_in),
        .q_id1(q_id1), .q_id2(q_id2), .q_hit1(q_hit1), .q_hit2(q_hit2)
    );

    typedef struct {
        int          id;
        logic [N-1:0] data;
        int          edge_no;
        bit          from_mem;
    } ent_t;

    int           checks = 0;
    int           errors = 0;
    ent_t         pendq[$];
    int           pend[R];
    logic [N-1:0] dut_rf[R];
    int           edge_no = 0;
    int           out_alu = 0, out_mem = 0;
    bit           infl_v = 1'b0;
    int           infl_id = 0;
    int           writes = 0, accepts = 0;
    bit           obs_wr;
    int           obs_id;
    bit           obs_alu_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        pendq.delete();
        for (int i = 0; i < R; i++) pend[i] = 0;
        out_alu = 0;
        out_mem = 0;
        infl_v  = 1'b0;
    endtask

    task automatic record(input int id, input logic [N-1:0] data, input bit from_mem);
        ent_t e;
        if (id != 0) begin
            e.id = id; e.data = data; e.edge_no = edge_no; e.from_mem = from_mem;
            pendq.push_back(e);
            pend[id]++;
            accepts++;
            if (from_mem) out_mem++; else out_alu++;
        end
    endtask

    // A write must be the oldest outstanding request to that register.
    task automatic observe_write();
        int idx = -1;
        for (int i = 0; i < pendq.size(); i++) begin
            if (idx < 0 && pendq[i].id == int'(reg_id_w)) idx = i;
        end
        check("write_expected", (idx >= 0), 1'b1);
        dut_rf[reg_id_w] = data_in;
        writes++;
        if (idx >= 0) begin
            check("write_data", data_in, pendq[idx].data);
            check("write_latency", ((edge_no - pendq[idx].edge_no) inside {[1:2]}), 1'b1);
            if (pendq[idx].from_mem) out_mem--; else out_alu--;
            infl_v  = 1'b1;
            infl_id = pendq[idx].id;
            pendq.delete(idx);
        end
    endtask

    task automatic cycle(input bit av, input int aid, input logic [N-1:0] ad,
                         input bit mv, input int mid, input logic [N-1:0] md);
        bit acc_a, acc_m;
        @(negedge clk);
        alu_valid = av; alu_id = AW'(aid); alu_data = ad;
        mem_valid = mv; mem_id = AW'(mid); mem_data = md;
        #1;
        check("q_hit1", q_hit1, (q_id1 != 0 && pend[q_id1] > 0));
        check("q_hit2", q_hit2, (q_id2 != 0 && pend[q_id2] > 0));
        if (out_alu == 0) check("alu_ready_idle", alu_ready, 1'b1);
        if (out_mem == 0) check("mem_ready_idle", mem_ready, 1'b1);
        obs_alu_ready = alu_ready;
        acc_a = av & alu_ready;
        acc_m = mv & mem_ready;
        @(posedge clk);
        #1;
        edge_no++;
        if (infl_v) begin
            pend[infl_id]--;
            infl_v = 1'b0;
        end
        if (acc_m) record(mid, md, 1'b1);
        if (acc_a) record(aid, ad, 1'b0);
        obs_wr = wr;
        obs_id = int'(reg_id_w);
        if (wr) observe_write();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, '0, 1'b0, 0, '0);
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 1'b0; mem_valid = 1'b0;
        alu_id = '0; mem_id = '0; alu_data = '0; mem_data = '0;
        q_id1 = '0; q_id2 = '0;
        model_clear();
        for (int i = 0; i < R; i++) dut_rf[i] = '0;
        #12;
        check("rst_wr", wr, 1'b0);
        check("rst_reg_id_w", reg_id_w, 5'd0);
        check("rst_data_in", data_in, 32'd0);
        check("rst_alu_ready", alu_ready, 1'b1);
        check("rst_mem_ready", mem_ready, 1'b1);
        check("rst_q_hit1", q_hit1, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Contention with the pointer favouring ALU: strict alternation starting with ALU.
        q_id1 = 5'd3; q_id2 = 5'd4;
        for (int k = 1; k <= 8; k++) begin
            if (k <= 6) cycle(1'b1, 3, 32'hA, 1'b1, 4, 32'hB);
            else        idle(1);
            if (k >= 2) begin
                check("cont_wr", obs_wr, 1'b1);
                check("cont_id", obs_id, (k % 2 == 0) ? 3 : 4);
            end
        end
        idle(1);
        check("cont_drained", obs_wr, 1'b0);

        // Single ALU request.
        q_id1 = 5'd5; q_id2 = 5'd6;
        cycle(1'b1, 5, 32'h1234, 1'b0, 0, '0);
        idle(1);
        check("single_wr", obs_wr, 1'b1);
        check("single_id", obs_id, 5);
        check("single_data", data_in, 32'h1234);
        idle(2);

        // Same register from both sources on one edge, then with ALU one edge earlier.
        q_id1 = 5'd7;
        cycle(1'b1, 7, 32'h22, 1'b1, 7, 32'h11);
        idle(3);
        check("same_edge_reg7", dut_rf[7], 32'h22);
        cycle(1'b1, 7, 32'h22, 1'b0, 0, '0);
        cycle(1'b0, 0, '0, 1'b1, 7, 32'h11);
        idle(3);
        check("alu_first_reg7", dut_rf[7], 32'h11);

        // Register 0 is accepted but never written nor reported pending.
        q_id1 = 5'd0;
        cycle(1'b1, 0, 32'hDEAD, 1'b0, 0, '0);
        check("reg0_ready", obs_alu_ready, 1'b1);
        idle(1);
        check("reg0_no_wr", obs_wr, 1'b0);
        idle(1);
        check("reg0_no_wr2", obs_wr, 1'b0);

        // Back-to-back ALU throughput.
        for (int k = 1; k <= 9; k++) begin
            if (k <= 8) cycle(1'b1, k, 32'h100 + k, 1'b0, 0, '0);
            else        idle(1);
            if (k <= 8) check("b2b_ready", obs_alu_ready, 1'b1);
            if (k >= 2) begin
                check("b2b_wr", obs_wr, 1'b1);
                check("b2b_id", obs_id, k - 1);
            end
        end
        idle(2);

        // Random traffic against the age-ordered model.
        for (int i = 0; i < 400; i++) begin
            q_id1 = AW'($urandom_range(0, 7));
            q_id2 = AW'($urandom_range(0, 31));
            cycle(1'($urandom_range(0, 1)), $urandom_range(0, 7), 32'($urandom),
                  1'($urandom_range(0, 1)), $urandom_range(0, 7), 32'($urandom));
        end
        idle(4);
        check("random_drained", pendq.size(), 0);
        check("random_write_count", writes, accepts);

        // Asynchronous reset mid-cycle with both sources holding requests.
        q_id1 = 5'd10;
        cycle(1'b1, 9, 32'h99, 1'b1, 10, 32'hAA);
        idle(1);
        check("pre_reset_wr", wr, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_wr", wr, 1'b0);
        check("async_rst_alu_ready", alu_ready, 1'b1);
        check("async_rst_mem_ready", mem_ready, 1'b1);
        check("async_rst_q_hit1", q_hit1, 1'b0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idle(1);
            check("post_rst_no_wr", obs_wr, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
